// File: rtl/arb_pkg.sv
// Package: arb_pkg
// Shared types and helpers for the priority arbiter (prio_arbiter_ctrl).
//   N_REQ       number of requesters (fixed at 8)
//   ID_W        width of a binary requester index
//   arb_state_t arbiter FSM states
//   prio_enc8   8:3 priority encoder, highest set bit wins (0 when no bit is set)
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  function automatic logic [ID_W-1:0] prio_enc8(input logic [N_REQ-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    // Ascending scan so the highest set bit is the last one to overwrite id.
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/prio_arbiter_ctrl_if.sv
// Interface: prio_arbiter_ctrl_if
// Request/grant bundle between the requesters and the arbiter.
//   req[7:0]   request lines, level-sensitive, bit 7 highest priority
//   mask[7:0]  1 = requester excluded from arbitration
//   done       owner releases the resource
//   gnt[7:0]   one-hot grant
//   gnt_id     binary index of the granted requester
//   gnt_valid  1 while a grant is held
//   timeout    1-cycle pulse when the hold watchdog forces a release
// Modports: master = requester side, slave = arbiter side.
interface prio_arbiter_ctrl_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mask;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, mask, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, mask, done,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

// File: rtl/arb_rotate_enc.sv
// Module: arb_rotate_enc
// Rotating priority encoder: searches vec starting at index start and moving downward with
// wrap (7 follows 0); the first set bit found wins.
//   vec[7:0]  candidate vector
//   start     first index examined (highest priority this round)
//   id        winning index (0 when nothing is found)
//   found     1 when any bit of vec is set
module arb_rotate_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [ID_W-1:0]  start,
  output logic [ID_W-1:0]  id,
  output logic             found
);

  logic [ID_W-1:0] idx;

  always_comb begin
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ID_W-bit subtraction gives the downward wrap for free.
      idx = start - ID_W'(i);
      if (!found && vec[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_ctrl.sv
// Module: prio_arbiter_ctrl
// Sequencing arbiter sharing one resource among 8 requesters. A grant is held until the owner
// signals done, drops its request, or the hold watchdog expires; each release is followed by one
// dead cycle before the next arbitration.
// Parameters:
//   HOLD_MAX  maximum grant length in cycles before forced release; 0 disables the watchdog
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       prio_arbiter_ctrl_if.slave (req, mask, done in; gnt, gnt_id, gnt_valid, timeout out)
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, search starts just below the last owner (rotating priority);
//                       otherwise fixed priority with bit 7 highest.
module prio_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_arbiter_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] eff;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             req_lost;
  logic             wd_fire;
  logic             release_req;

  assign eff = bus.req & ~bus.mask;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_start;
  // Last owner becomes lowest priority: start one below it.
  assign rr_start = last_id_q - ID_W'(1);

  arb_rotate_enc u_rotate_enc (
    .vec   (eff),
    .start (rr_start),
    .id    (win_id),
    .found (win_found)
  );
`else
  assign win_id    = prio_enc8(eff);
  assign win_found = |eff;

  // last_id is tracked in both builds but only steers the rotating search.
  logic unused_last_id;
  assign unused_last_id = ^last_id_q;
`endif

  assign req_lost    = ~bus.req[gnt_id_q];
  assign wd_fire     = (HOLD_MAX != 0) && (hold_cnt_q == CNT_LAST);
  assign release_req = bus.done | req_lost | wd_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_id_q   <= '0;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt  = GRANT;
          gnt_id_d   = win_id;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (hold_cnt_q != CNT_SAT) hold_cnt_d = hold_cnt_q + CNT_W'(1);
        if (release_req) begin
          state_nxt = RELEASE;
          last_id_d = gnt_id_q;
          // Flag only releases forced purely by the watchdog.
          timeout_d = wd_fire & ~bus.done & ~req_lost;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: decoded from registered state only
  always_comb begin
    bus.gnt_valid = (state == GRANT);
    bus.gnt       = '0;
    if (state == GRANT) bus.gnt[gnt_id_q] = 1'b1;
    bus.gnt_id    = gnt_id_q;
    bus.timeout   = timeout_q;
  end

endmodule
